// File: rtl/bist_pkg.sv
// Shared types, tables and helpers for the exhaustive BIST controller.
//   bist_state_e : controller FSM states
//   LFSR_TAPS    : maximal-length Fibonacci tap masks for widths 2..16 (shift-left form,
//                  feedback = XOR of masked bits, shifted into bit 0)
//   misr_poly    : Galois MISR feedback polynomial for signature widths 8/16/32
//   misr_next    : one MISR step: Galois shift, then XOR of zero-extended response
package bist_pkg;

  typedef enum logic [1:0] {StIdle, StApply, StCapture, StDone} bist_state_e;

  localparam logic [15:0] LFSR_TAPS [2:16] = '{
    16'h0003, 16'h0006, 16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110,
    16'h0240, 16'h0500, 16'h0829, 16'h100D, 16'h2015, 16'h6000, 16'hD008
  };

  localparam logic [31:0] MISR_POLY_8  = 32'h0000_001D;
  localparam logic [31:0] MISR_POLY_16 = 32'h0000_1021;
  localparam logic [31:0] MISR_POLY_32 = 32'h04C1_1DB7;

  function automatic logic [31:0] misr_poly(int unsigned width);
    case (width)
      8:       return MISR_POLY_8;
      32:      return MISR_POLY_32;
      default: return MISR_POLY_16;
    endcase
  endfunction

  // Operates on a 32-bit container; bits above width are masked off.
  function automatic logic [31:0] misr_next(logic [31:0] cur, logic [31:0] data,
                                            int unsigned width);
    logic [31:0] mask;
    logic [31:0] shifted;
    logic        msb;
    mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    msb     = |(cur & (32'd1 << (width - 1)));
    shifted = (cur << 1) & mask;
    if (msb) begin
      shifted = shifted ^ misr_poly(width);
    end
    return (shifted ^ data) & mask;
  endfunction

endpackage

// File: rtl/exhaustive_bist_ctrl_if.sv
// Bus between a BIST controller and its host/circuit-under-test harness.
//   start     : host -> ctrl, begin a run
//   dut_out   : CUT response -> ctrl
//   dut_in    : ctrl -> CUT stimulus vector
//   busy/done : run status
//   pass      : signature matches golden (only while done)
//   signature : current MISR contents
//   vec_idx   : vectors captured so far
// Modports: master = host side, slave = controller side.
interface exhaustive_bist_ctrl_if #(
  parameter int unsigned N_IN   = 5,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned MISR_W = 16
);
  logic              start;
  logic [N_IN-1:0]   dut_in;
  logic [N_OUT-1:0]  dut_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [MISR_W-1:0] signature;
  logic [N_IN:0]     vec_idx;

  modport master (
    output start, dut_out,
    input  dut_in, busy, done, pass, signature, vec_idx
  );

  modport slave (
    input  start, dut_out,
    output dut_in, busy, done, pass, signature, vec_idx
  );
endinterface

// File: rtl/bist_pattern_gen.sv
// Test pattern source for the exhaustive BIST controller.
// Build option BIST_LFSR_PATTERN_EN:
//   defined   : all-zero vector, then a maximal-length Fibonacci LFSR seeded to 1
//   undefined : binary up-counter 0 .. 2^N_IN-1
// Either way exactly 2^N_IN distinct vectors are produced.
// Ports:
//   clk, rst : clock, synchronous active-high reset (pattern returns to vector 0)
//   clear    : restart from vector 0
//   advance  : step to the next vector
//   pattern  : current vector
//   last     : current vector is the final one of the sequence
module bist_pattern_gen
  import bist_pkg::*;
#(
  parameter int unsigned N_IN = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            advance,
  output logic [N_IN-1:0] pattern,
  output logic            last
);

`ifdef BIST_LFSR_PATTERN_EN

  localparam logic [N_IN-1:0] TAPS       = N_IN'(LFSR_TAPS[N_IN]);
  // The state that feeds back into the seed: only the top bit set.
  localparam logic [N_IN-1:0] LAST_STATE = {1'b1, {(N_IN-1){1'b0}}};

  logic [N_IN-1:0] lfsr_q;
  logic            zero_q;  // still presenting the inserted all-zero vector

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lfsr_q <= N_IN'(1);
      zero_q <= 1'b1;
    end else if (advance) begin
      if (zero_q) begin
        zero_q <= 1'b0;
      end else begin
        lfsr_q <= {lfsr_q[N_IN-2:0], ^(lfsr_q & TAPS)};
      end
    end
  end

  assign pattern = zero_q ? '0 : lfsr_q;
  assign last    = !zero_q && (lfsr_q == LAST_STATE);

`else

  logic [N_IN-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (advance) begin
      cnt_q <= cnt_q + N_IN'(1);
    end
  end

  assign pattern = cnt_q;
  assign last    = &cnt_q;

`endif

endmodule

// File: rtl/exhaustive_bist_ctrl.sv
// Exhaustive BIST controller: applies all 2^N_IN vectors to a combinational CUT, holds each
// for SETTLE+1 cycles, and compacts the responses into a Galois MISR. A start pulse runs the
// whole sequence; done then holds with pass = (signature == GOLDEN).
// Build option BIST_LFSR_PATTERN_EN selects LFSR pattern order (see bist_pattern_gen).
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset, returns all outputs to 0
//   bus : exhaustive_bist_ctrl_if.slave (start, dut_in, dut_out, busy, done, pass,
//         signature, vec_idx)
module exhaustive_bist_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned       N_IN   = 5,
  parameter int unsigned       N_OUT  = 2,
  parameter int unsigned       SETTLE = 2,
  parameter int unsigned       MISR_W = 16,
  parameter logic [MISR_W-1:0] GOLDEN = '0
) (
  input logic                    clk,
  input logic                    rst,
  exhaustive_bist_ctrl_if.slave  bus
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned VW = N_IN + 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

  bist_state_e       state_q;
  logic [SW-1:0]     settle_q;
  logic [MISR_W-1:0] misr_q;
  logic [VW-1:0]     vec_idx_q;
  logic              busy_q;
  logic              done_q;

  logic [N_IN-1:0]   pattern;
  logic              last;
  logic              launch;
  logic              advance;

  assign launch  = ((state_q == StIdle) || (state_q == StDone)) && bus.start;
  assign advance = (state_q == StCapture) && !last;

  bist_pattern_gen #(
    .N_IN (N_IN)
  ) u_pattern_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (launch),
    .advance (advance),
    .pattern (pattern),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      settle_q  <= '0;
      misr_q    <= '0;
      vec_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_q   <= StApply;
            settle_q  <= SETTLE_LOAD;
            misr_q    <= '0;
            vec_idx_q <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        StApply: begin
          if (settle_q == '0) begin
            state_q <= StCapture;
          end else begin
            settle_q <= settle_q - SW'(1);
          end
        end
        StCapture: begin
          misr_q    <= MISR_W'(misr_next(32'(misr_q), 32'(bus.dut_out), MISR_W));
          vec_idx_q <= vec_idx_q + VW'(1);
          if (last) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q  <= StApply;
            settle_q <= SETTLE_LOAD;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.dut_in    = pattern;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.signature = misr_q;
  assign bus.vec_idx   = vec_idx_q;
  assign bus.pass      = done_q && (misr_q == GOLDEN);

endmodule

// File: tb/tb_exhaustive_bist_ctrl.sv
// Bench for exhaustive_bist_ctrl: three controllers run in lockstep on a shared start/rst,
// each feeding its own copy of the c17 CUT model. They differ only in GOLDEN: zero, the
// fault-free c17 signature, and that signature with bit 0 flipped.
module tb_exhaustive_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_drv;
  logic [1:0] mode;  // 0: CUT outputs tied 0, 1: c17, 2: c17 with N22 stuck at 0

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] seq [32];

  always #5 clk = ~clk;

  // Inputs N1,N2,N3,N6,N7 on bits 0..4; outputs N22 (bit 0), N23 (bit 1).
  function automatic logic [1:0] c17(logic [4:0] v);
    logic n10, n11, n16, n19;
    n10 = ~(v[0] & v[2]);
    n11 = ~(v[2] & v[3]);
    n16 = ~(v[1] & n11);
    n19 = ~(n11 & v[4]);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic logic [4:0] vec_at(int i);
`ifdef BIST_LFSR_PATTERN_EN
    logic [4:0] s;
    if (i == 0) return 5'd0;
    s = 5'd1;
    for (int k = 1; k < i; k++) s = {s[3:0], s[4] ^ s[2]};
    return s;
`else
    logic [31:0] iv;
    iv = i;
    return iv[4:0];
`endif
  endfunction

  function automatic logic [1:0] resp(logic [4:0] v, logic [1:0] m);
    logic [1:0] o;
    if (m == 2'd0) return 2'b00;
    o = c17(v);
    if (m == 2'd2) o[0] = 1'b0;
    return o;
  endfunction

  function automatic logic [15:0] ref_sig(logic fault);
    logic [15:0] m;
    logic [1:0]  o;
    logic        fb;
    m = 16'h0;
    for (int i = 0; i < 32; i++) begin
      o = c17(vec_at(i));
      if (fault) o[0] = 1'b0;
      fb = m[15];
      m  = {m[14:0], 1'b0};
      if (fb) m = m ^ 16'h1021;
      m = m ^ {14'd0, o};
    end
    return m;
  endfunction

  localparam logic [15:0] REF_SIG   = ref_sig(1'b0);
  localparam logic [15:0] REF_FAULT = ref_sig(1'b1);

  exhaustive_bist_ctrl_if #(.N_IN(5), .N_OUT(2), .MISR_W(16)) bif0 ();
  exhaustive_bist_ctrl_if #(.N_IN(5), .N_OUT(2), .MISR_W(16)) bif1 ();
  exhaustive_bist_ctrl_if #(.N_IN(5), .N_OUT(2), .MISR_W(16)) bif2 ();

  assign bif0.start   = start_drv;
  assign bif1.start   = start_drv;
  assign bif2.start   = start_drv;
  assign bif0.dut_out = resp(bif0.dut_in, mode);
  assign bif1.dut_out = resp(bif1.dut_in, mode);
  assign bif2.dut_out = resp(bif2.dut_in, mode);

  exhaustive_bist_ctrl #(
    .N_IN(5), .N_OUT(2), .SETTLE(2), .MISR_W(16), .GOLDEN(16'h0000)
  ) u_dut_zero (.clk(clk), .rst(rst), .bus(bif0));

  exhaustive_bist_ctrl #(
    .N_IN(5), .N_OUT(2), .SETTLE(2), .MISR_W(16), .GOLDEN(REF_SIG)
  ) u_dut_c17 (.clk(clk), .rst(rst), .bus(bif1));

  exhaustive_bist_ctrl #(
    .N_IN(5), .N_OUT(2), .SETTLE(2), .MISR_W(16), .GOLDEN(REF_SIG ^ 16'h0001)
  ) u_dut_flip (.clk(clk), .rst(rst), .bus(bif2));

  // Returns at the negedge following the start edge (cycle 0 of the run).
  task automatic pulse_start();
    @(negedge clk);
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bif1.done !== 1'b1 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_drv = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bif0.dut_in !== 5'd0) begin n_fail++;
      $display("FAIL reset_dut_in: got %0h expected 0", bif0.dut_in); end
    n_checks++; if (bif0.busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy: got %0b expected 0", bif0.busy); end
    n_checks++; if (bif0.done !== 1'b0) begin n_fail++;
      $display("FAIL reset_done: got %0b expected 0", bif0.done); end
    n_checks++; if (bif0.pass !== 1'b0) begin n_fail++;
      $display("FAIL reset_pass: got %0b expected 0", bif0.pass); end
    n_checks++; if (bif0.signature !== 16'h0) begin n_fail++;
      $display("FAIL reset_signature: got %0h expected 0", bif0.signature); end
    n_checks++; if (bif0.vec_idx !== 6'd0) begin n_fail++;
      $display("FAIL reset_vec_idx: got %0d expected 0", bif0.vec_idx); end
    rst = 1'b0;
  endtask

  task automatic test_counter_zero();
    mode = 2'd0;
    pulse_start();
    for (int j = 0; j < 96; j++) begin
      n_checks++; if (bif0.dut_in !== seq[j/3]) begin n_fail++;
        $display("FAIL seq_dut_in cycle %0d: got %0h expected %0h", j, bif0.dut_in, seq[j/3]);
      end
      n_checks++; if (bif0.vec_idx !== 6'(j/3)) begin n_fail++;
        $display("FAIL seq_vec_idx cycle %0d: got %0d expected %0d", j, bif0.vec_idx, j/3);
      end
      n_checks++; if (bif0.busy !== 1'b1 || bif0.done !== 1'b0) begin n_fail++;
        $display("FAIL seq_busy_done cycle %0d: got %0b%0b expected 10", j, bif0.busy,
                 bif0.done);
      end
      @(negedge clk);
    end
    n_checks++; if (bif0.done !== 1'b1 || bif0.busy !== 1'b0) begin n_fail++;
      $display("FAIL zero_done_at_96: got busy=%0b done=%0b expected busy=0 done=1",
               bif0.busy, bif0.done); end
    n_checks++; if (bif0.signature !== 16'h0) begin n_fail++;
      $display("FAIL zero_signature: got %0h expected 0", bif0.signature); end
    n_checks++; if (bif0.pass !== 1'b1) begin n_fail++;
      $display("FAIL zero_pass: got %0b expected 1", bif0.pass); end
    n_checks++; if (bif0.vec_idx !== 6'd32) begin n_fail++;
      $display("FAIL zero_vec_idx: got %0d expected 32", bif0.vec_idx); end
    repeat (4) @(negedge clk);
    n_checks++; if (bif0.done !== 1'b1 || bif0.pass !== 1'b1) begin n_fail++;
      $display("FAIL zero_done_held: got done=%0b pass=%0b expected 1 1", bif0.done,
               bif0.pass); end
  endtask

  task automatic test_pattern_order();
    logic [4:0]  first [32];
    logic [31:0] seen;
    int          distinct;
    mode = 2'd0;
    pulse_start();
    for (int j = 0; j < 96; j++) begin
      if (j % 3 == 0) first[j/3] = bif0.dut_in;
      @(negedge clk);
    end
    seen = '0;
    distinct = 0;
    for (int i = 0; i < 32; i++) begin
      if (!seen[first[i]]) distinct++;
      seen[first[i]] = 1'b1;
    end
    n_checks++; if (distinct != 32) begin n_fail++;
      $display("FAIL order_distinct: got %0d expected 32", distinct); end
    n_checks++; if (first[0] !== 5'd0) begin n_fail++;
      $display("FAIL order_first: got %0h expected 0", first[0]); end
    n_checks++; if (first[1] !== 5'd1) begin n_fail++;
      $display("FAIL order_second: got %0h expected 1", first[1]); end
    n_checks++; if (bif0.vec_idx !== 6'd32 || bif0.done !== 1'b1) begin n_fail++;
      $display("FAIL order_vec_idx_done: got %0d/%0b expected 32/1", bif0.vec_idx,
               bif0.done); end
  endtask

  task automatic test_c17();
    int cycles;
    mode = 2'd1;
    pulse_start();  // launched from DONE: must restart immediately
    n_checks++; if (bif1.busy !== 1'b1 || bif1.done !== 1'b0) begin n_fail++;
      $display("FAIL restart_busy_done: got %0b%0b expected 10", bif1.busy, bif1.done); end
    n_checks++; if (bif1.signature !== 16'h0 || bif1.vec_idx !== 6'd0) begin n_fail++;
      $display("FAIL restart_cleared: got sig=%0h idx=%0d expected 0 0", bif1.signature,
               bif1.vec_idx); end
    n_checks++; if (bif1.dut_in !== 5'd0) begin n_fail++;
      $display("FAIL restart_dut_in: got %0h expected 0", bif1.dut_in); end
    wait_done(cycles);
    n_checks++; if (cycles != 96) begin n_fail++;
      $display("FAIL c17_latency: got %0d expected 96", cycles); end
    n_checks++; if (bif1.signature !== REF_SIG) begin n_fail++;
      $display("FAIL c17_signature: got %0h expected %0h", bif1.signature, REF_SIG); end
    n_checks++; if (bif1.pass !== 1'b1) begin n_fail++;
      $display("FAIL c17_pass: got %0b expected 1", bif1.pass); end
    n_checks++; if (bif2.signature !== REF_SIG) begin n_fail++;
      $display("FAIL flip_signature: got %0h expected %0h", bif2.signature, REF_SIG); end
    n_checks++; if (bif2.pass !== 1'b0) begin n_fail++;
      $display("FAIL flip_pass: got %0b expected 0", bif2.pass); end
  endtask

  task automatic test_stuck_fault();
    int cycles;
    mode = 2'd2;
    pulse_start();
    wait_done(cycles);
    n_checks++; if (cycles != 96) begin n_fail++;
      $display("FAIL fault_latency: got %0d expected 96", cycles); end
    n_checks++; if (bif1.signature !== REF_FAULT) begin n_fail++;
      $display("FAIL fault_signature: got %0h expected %0h", bif1.signature, REF_FAULT); end
    n_checks++; if (bif1.signature === REF_SIG) begin n_fail++;
      $display("FAIL fault_differs: got %0h expected not %0h", bif1.signature, REF_SIG); end
    n_checks++; if (bif1.pass !== 1'b0) begin n_fail++;
      $display("FAIL fault_pass: got %0b expected 0", bif1.pass); end
  endtask

  task automatic test_reset_midrun();
    int cycles;
    mode = 2'd1;
    pulse_start();
    repeat (31) @(negedge clk);
    n_checks++; if (bif1.dut_in !== seq[10]) begin n_fail++;
      $display("FAIL midrun_vector10: got %0h expected %0h", bif1.dut_in, seq[10]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if ({bif1.busy, bif1.done, bif1.pass} !== 3'b000) begin n_fail++;
      $display("FAIL midrun_rst_flags: got %0b expected 000",
               {bif1.busy, bif1.done, bif1.pass}); end
    n_checks++; if (bif1.dut_in !== 5'd0 || bif1.vec_idx !== 6'd0) begin n_fail++;
      $display("FAIL midrun_rst_idx: got in=%0h idx=%0d expected 0 0", bif1.dut_in,
               bif1.vec_idx); end
    n_checks++; if (bif1.signature !== 16'h0) begin n_fail++;
      $display("FAIL midrun_rst_signature: got %0h expected 0", bif1.signature); end
    repeat (3) @(negedge clk);
    n_checks++; if (bif1.busy !== 1'b0 || bif1.dut_in !== 5'd0) begin n_fail++;
      $display("FAIL midrun_stays_idle: got busy=%0b in=%0h expected 0 0", bif1.busy,
               bif1.dut_in); end
    pulse_start();
    wait_done(cycles);
    n_checks++; if (cycles != 96) begin n_fail++;
      $display("FAIL rerun_latency: got %0d expected 96", cycles); end
    n_checks++; if (bif1.signature !== REF_SIG || bif1.pass !== 1'b1) begin n_fail++;
      $display("FAIL rerun_signature: got %0h pass=%0b expected %0h pass=1",
               bif1.signature, bif1.pass, REF_SIG); end
  endtask

  task automatic test_start_ignored();
    int j;
    mode = 2'd1;
    pulse_start();
    j = 0;
    while (bif1.done !== 1'b1 && j < 200) begin
      if (j == 9) begin
        n_checks++; if (bif1.dut_in !== seq[3]) begin n_fail++;
          $display("FAIL ignore_at_vec3: got %0h expected %0h", bif1.dut_in, seq[3]); end
      end
      if (j == 60) begin
        n_checks++; if (bif1.dut_in !== seq[20]) begin n_fail++;
          $display("FAIL ignore_at_vec20: got %0h expected %0h", bif1.dut_in, seq[20]); end
      end
      start_drv = (j == 9 || j == 60);
      @(negedge clk);
      j++;
    end
    start_drv = 1'b0;
    n_checks++; if (j != 96) begin n_fail++;
      $display("FAIL ignore_latency: got %0d expected 96", j); end
    n_checks++; if (bif1.signature !== REF_SIG || bif1.pass !== 1'b1) begin n_fail++;
      $display("FAIL ignore_signature: got %0h pass=%0b expected %0h pass=1",
               bif1.signature, bif1.pass, REF_SIG); end
  endtask

  initial begin
    rst = 1'b1;
    start_drv = 1'b0;
    mode = 2'd0;
    for (int i = 0; i < 32; i++) seq[i] = vec_at(i);
    test_reset();
    test_counter_zero();
    test_pattern_order();
    test_c17();
    test_stuck_fault();
    test_reset_midrun();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
